keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
- Scans the calculator's 4x4 matrix keypad by driving columns one-hot and sampling rows.
- Debounces presses and releases and encodes each press into a logical key code.
- Delivers exactly one key event per press to the calculator core over a valid/ready handshake.
- Replaces ad-hoc scanning inside the arithmetic block, which then only consumes key events. Runs on the 6 MHz system clock.

Parameters:
- SCAN_DIV, 30000: system clocks per scan tick (5 ms at 6 MHz); legal range >= 2.
- DEBOUNCE_N, 4: consecutive matching samples needed to accept a press or a release; legal range 1..15.

Ports:
- clk  input  1  system clock, 6 MHz.
- reset  input  1  reset, asynchronous, active-low.
- row_in  input  4  keypad rows; bit r high = key in row r of the driven column closed.
- col_out  output  4  one-hot column drive, active high.
- key_valid  output  1  key event pending.
- key_code  output  4  logical key code; stable while key_valid is high.
- key_ready  input  1  consumer accepts the event; transfer occurs when key_valid && key_ready.
- key_lost  output  1  one-cycle pulse: accepted press dropped because the buffer was full.
- key_down  output  1  high while a debounced press is held.

Behaviour:
- Reset values (asynchronous): col_out=4'b0001, key_valid=0, key_code=0, key_lost=0, key_down=0, prescaler=0, state=SCAN, counters=0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick is a one-clock pulse on the count SCAN_DIV-1. All FSM actions below happen only on tick cycles.
- Key map (row r, column c -> code):
  - c0: r0..r2 = 1,2,3; r3 = X(10).
  - c1: r0..r2 = 4,5,6; r3 = Y(11).
  - c2: r0..r2 = 7,8,9; r3 = CLR(12).
  - c3: r0 = 0, r1 = ADD(13), r2 = SUB(14), r3 = EQ(15).
- Row sampling: rows are sampled for the column currently on col_out, before any rotation in the same tick.
- FSM SCAN:
  - If row_in is exactly one-hot: capture row and column, set cnt=1, freeze col_out. Go DEBOUNCE, or go straight to the accept path if DEBOUNCE_N=1.
  - If row_in is zero or has more than one bit set: rotate col_out (0001->0010->0100->1000->0001).
- FSM DEBOUNCE (column frozen):
  - row_in == captured row: cnt++. When cnt reaches DEBOUNCE_N, accept the press, set key_down=1, go HELD with rel_cnt=0.
  - Otherwise: go SCAN and rotate col_out to the next column.
- FSM HELD (column frozen, no auto-repeat):
  - Captured row bit low: rel_cnt++.
  - Captured row bit high: rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE_N: key_down=0, go SCAN, rotate col_out.
  - Other rows in HELD are ignored.
- Accept path (single-entry output buffer):
  - key_valid=0: key_valid=1 and key_code=code on the next clock.
  - key_valid=1 with key_ready=1 in the same cycle: the new code replaces the old one and key_valid stays 1.
  - key_valid=1 with key_ready=0: the new code is dropped, key_code is unchanged, and key_lost pulses for one clock.
- Handshake rules:
  - key_valid and key_code hold until the transfer.
  - key_valid falls the clock after the transfer unless a replacement arrives in that cycle.
  - key_ready while key_valid=0 has no effect.
- Latency:
  - A key held from before the first tick of its column produces key_valid one clock after that column's DEBOUNCE_N-th tick.
  - Worst case (DEBOUNCE_N+3) ticks + 1 clock.
- Width rules: cnt and rel_cnt are 4 bits and saturate at DEBOUNCE_N. Code encoding is {row,col} -> table lookup; no arithmetic.
- Reset mid-operation: everything returns to reset values immediately. A pending event is discarded. A key still held after reset release is re-detected as a new press.

Decomposition:
- Shared package calc_pkg holds:
  - key code constants: KEY_0..KEY_9 = 0..9, KEY_X = 10, KEY_Y = 11, KEY_CLR = 12, KEY_ADD = 13, KEY_SUB = 14, KEY_EQ = 15;
  - the FSM state enum (SCAN, DEBOUNCE, HELD);
  - the row/column-to-code lookup function.
- Sub-module scan_tick_gen: a parameterised prescaler emitting the one-clock tick. It is reused by the 7-segment display multiplexer.

Test Plan (SCAN_DIV=4, DEBOUNCE_N=3):
- Press r1/c3 held for 20 ticks, key_ready=1 -> exactly one event, key_code=13 (ADD), within 6 ticks of press; key_down high until release debounced.
- Bounce: row high 2 ticks, low, high 1 tick, low -> no key_valid; col_out resumes rotation.
- Press 5, keep key_ready=0, release, press 9 -> key_code stays 5 with key_valid held; key_lost pulses once. Then key_ready=1 for one clock -> key_valid falls.
- In c0, assert r0 and r2 simultaneously -> ignored, rotation continues. Release r2 -> event code 1.
- Release glitch in HELD: 2 low ticks, 1 high, then 3 low -> single event; second press of same key accepted only after the release completes.
- Assert reset low mid-DEBOUNCE and in HELD with event pending -> col_out=0001, key_valid=0, key_down=0 immediately. Key still held after reset release -> new event.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc_pkg -- shared calculator key codes, keypad scan states, key-map lookup
// Rev 1.0
// ----------------------------------------------------------------------------
package calc_pkg;

  localparam logic [3:0] KEY_0   = 4'd0;
  localparam logic [3:0] KEY_1   = 4'd1;
  localparam logic [3:0] KEY_2   = 4'd2;
  localparam logic [3:0] KEY_3   = 4'd3;
  localparam logic [3:0] KEY_4   = 4'd4;
  localparam logic [3:0] KEY_5   = 4'd5;
  localparam logic [3:0] KEY_6   = 4'd6;
  localparam logic [3:0] KEY_7   = 4'd7;
  localparam logic [3:0] KEY_8   = 4'd8;
  localparam logic [3:0] KEY_9   = 4'd9;
  localparam logic [3:0] KEY_X   = 4'd10;
  localparam logic [3:0] KEY_Y   = 4'd11;
  localparam logic [3:0] KEY_CLR = 4'd12;
  localparam logic [3:0] KEY_ADD = 4'd13;
  localparam logic [3:0] KEY_SUB = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_e;

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Index is {row, col}; pure table, no arithmetic on the position.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_4;
      4'b00_10: code = KEY_7;
      4'b00_11: code = KEY_0;
      4'b01_00: code = KEY_2;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_8;
      4'b01_11: code = KEY_ADD;
      4'b10_00: code = KEY_3;
      4'b10_01: code = KEY_6;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_SUB;
      4'b11_00: code = KEY_X;
      4'b11_01: code = KEY_Y;
      4'b11_10: code = KEY_CLR;
      default:  code = KEY_EQ;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scan_tick_gen -- free-running prescaler, one-clock tick every DIV clocks
// Rev 1.0
// ----------------------------------------------------------------------------
module scan_tick_gen #(
  parameter int DIV = 30000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int          W    = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keypad_scan_ctrl -- 4x4 keypad scanner, debouncer and key-event buffer
// Rev 1.0
// ----------------------------------------------------------------------------
module keypad_scan_ctrl
  import calc_pkg::*;
#(
  parameter int SCAN_DIV   = 30000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_lost,
  output logic       key_down
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_N);

  logic       tick;
  kp_state_e  state_q, state_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  logic [3:0] cnt_q, cnt_d, rel_q, rel_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d, lost_q, lost_d, down_q, down_d;
  logic       accept;
  logic [3:0] col_next, cnt_inc, rel_inc, new_code;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  assign col_next = {col_q[2:0], col_q[3]};
  assign cnt_inc  = (cnt_q >= DEB_N) ? DEB_N : cnt_q + 4'd1;
  assign rel_inc  = (rel_q >= DEB_N) ? DEB_N : rel_q + 4'd1;
  // At accept time row_in equals the captured row, so decode it directly.
  assign new_code = key_lookup(onehot_idx(row_in), onehot_idx(col_q));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    down_d  = down_q;
    accept  = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if ($onehot(row_in)) begin
            row_d = row_in;
            cnt_d = 4'd1;
            if (DEB_N == 4'd1) begin
              accept  = 1'b1;
              down_d  = 1'b1;
              rel_d   = 4'd0;
              state_d = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_next;
          end
        end
        DEBOUNCE: begin
          if (row_in == row_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_N) begin
              accept  = 1'b1;
              down_d  = 1'b1;
              rel_d   = 4'd0;
              state_d = HELD;
            end
          end else begin
            col_d   = col_next;
            state_d = SCAN;
          end
        end
        HELD: begin
          if ((row_in & row_q) == 4'd0) begin
            rel_d = rel_inc;
            if (rel_inc == DEB_N) begin
              down_d  = 1'b0;
              col_d   = col_next;
              state_d = SCAN;
            end
          end else begin
            rel_d = 4'd0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Single-entry buffer: a completing transfer frees the slot in the same cycle.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    lost_d  = 1'b0;
    if (accept) begin
      if (!valid_q || key_ready) begin
        valid_d = 1'b1;
        code_d  = new_code;
      end else begin
        lost_d = 1'b1;
      end
    end else if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SCAN;
      col_q   <= 4'b0001;
      row_q   <= 4'd0;
      cnt_q   <= 4'd0;
      rel_q   <= 4'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
      down_q  <= down_d;
    end
  end

  assign col_out   = col_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_lost  = lost_q;
  assign key_down  = down_q;

endmodule
`default_nettype wire
